int_ret_sequencer: RTL and testbench
====================================

// Module: int_ret_sequencer
// PURPOSE
//  Multi-cycle control FSM for interrupt entry, RET and RTI. Drives the 2-bit
//  count and int flag consumed by the hazard detection unit, sequences stack
//  pushes/pops on the shared data-memory port and steers PC/flag restore.
//  Sits beside the HDU between decode/execute control and the memory stage.
// PARAMETERS
//  PC_W      32     program counter width
//  VEC_ADDR  32'd1  data-memory address of the interrupt vector word
// PORTS
//  clk          in   1     system clock, all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  int_req      in   1     external interrupt request, single-cycle pulse
//  ret_ex       in   1     RET in execute stage, one cycle per instruction
//  rti_ex       in   1     RTI in execute stage, one cycle per instruction
//  load_stall   in   1     HDU load-use stall active this cycle
//  count        out  2     cycles remaining in current sequence (0 = idle)
//  int_active   out  1     interrupt entry in progress (HDU int input)
//  int_ack      out  1     one-cycle pulse when interrupt entry is accepted
//  mem_op       out  2     00 none, 01 push (SP-1, write), 10 pop (read, SP+1)
//  mem_src      out  1     push data select: 0 = PC, 1 = flags
//  vec_rd       out  1     read VEC_ADDR, load result into PC
//  pc_from_mem  out  1     load PC from popped word
//  flags_from_mem out 1    load CCR from popped word
//  flush        out  1     flush IF/ID and ID/EX buffers this cycle
// BEHAVIOUR
//  Reset (sync): state IDLE, pending=0; all outputs 0.
//  pending: set by int_req, cleared on int_ack; int_req while pending or
//   while INT sequence active is absorbed (no queue depth beyond one).
//  States / outputs (one cycle each, count shown):
//   IDLE       count=0; no memory op.
//   INT_PC     count=3, int_active=1, mem_op=01, mem_src=0, flush=1
//   INT_FLG    count=2, int_active=1, mem_op=01, mem_src=1
//   INT_VEC    count=1, int_active=1, vec_rd=1, flush=1
//   RET_PC     count=1, mem_op=10, pc_from_mem=1, flush=1
//   RTI_FLG    count=2, mem_op=10, flags_from_mem=1, flush=1
//   RTI_PC     count=1, mem_op=10, pc_from_mem=1, flush=1
//  Transitions from IDLE (priority high->low):
//   ret_ex -> RET_PC; rti_ex -> RTI_FLG (ret_ex & rti_ex together: RET wins);
//   pending & !load_stall -> INT_PC, int_ack=1 on the transition cycle.
//  INT_PC->INT_FLG->INT_VEC->IDLE; RET_PC->IDLE; RTI_FLG->RTI_PC->IDLE.
//  Sequences never abort: ret_ex/rti_ex/int_req arriving mid-sequence do not
//   alter the current sequence; ret_ex/rti_ex outside IDLE are ignored (the
//   flush guarantees none are in flight); int_req only sets pending.
//  Interrupt arriving with RET/RTI in execute: return completes first, then
//   interrupt entry starts the cycle after returning to IDLE.
//  load_stall in IDLE defers interrupt entry; does not affect active sequence.
//  Latency: int_req at cycle N (IDLE, no stall) -> INT_PC at N+1 (pending
//   registered) ; PC holds vector after INT_VEC, fetch resumes at N+4.
//  Stack order: PC pushed then flags; RTI pops flags then PC (LIFO match).
//  All outputs are decoded from registered state (Moore), except int_ack.
//  Reset mid-sequence: next edge returns to IDLE, pending cleared, no partial
//   memory op issued after reset.
// TESTING
//  rst=1 2 cycles -> count=0, mem_op=00, flush=0, int_active=0, pending=0.
//  int_req pulse in IDLE -> count 3,2,1,0; mem_op 01,01,00; mem_src 0,1; vec_rd
//   in 3rd cycle; int_ack exactly once.
//  rti_ex=1 one cycle -> RTI_FLG then RTI_PC: flags_from_mem then pc_from_mem,
//   mem_op=10 both cycles, flush=1 both, then IDLE.
//  int_req and ret_ex same cycle -> RET_PC first (count=1), then INT_PC..INT_VEC;
//   int_ack asserted only on the IDLE->INT_PC edge.
//  int_req while load_stall=1 for 3 cycles -> stays IDLE count=0; INT_PC on
//   first cycle after load_stall falls.
//  rst=1 during INT_FLG -> next cycle IDLE, all outputs 0, later int_req
//   produces full fresh 3-cycle sequence.

Source files
------------

// File: rtl/int_ret_sequencer.sv
// Interrupt-entry / RET / RTI control sequencer. It drives the HDU count and int
// flags, schedules stack push/pop on the shared data port, and steers PC/CCR restore.
module int_ret_sequencer #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] VEC_ADDR = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       ret_ex,
  input  logic       rti_ex,
  input  logic       load_stall,
  output logic [1:0] count,
  output logic       int_active,
  output logic       int_ack,
  output logic [1:0] mem_op,
  output logic       mem_src,
  output logic       vec_rd,
  output logic       pc_from_mem,
  output logic       flags_from_mem,
  output logic       flush
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INT_PC  = 3'd1,
    INT_FLG = 3'd2,
    INT_VEC = 3'd3,
    RET_PC  = 3'd4,
    RTI_FLG = 3'd5,
    RTI_PC  = 3'd6
  } state_t;

  typedef struct packed {
    logic [1:0] count;
    logic       int_active;
    logic [1:0] mem_op;
    logic       mem_src;
    logic       vec_rd;
    logic       pc_from_mem;
    logic       flags_from_mem;
    logic       flush;
  } ctrl_t;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_PUSH = 2'b01;
  localparam logic [1:0] MEM_POP  = 2'b10;

  // Per-state control word; the outputs are a pure function of the state.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      IDLE:    c = '0;
      INT_PC:  begin c.count = 2'd3; c.int_active = 1'b1; c.mem_op = MEM_PUSH;
                     c.mem_src = 1'b0; c.flush = 1'b1; end
      INT_FLG: begin c.count = 2'd2; c.int_active = 1'b1; c.mem_op = MEM_PUSH;
                     c.mem_src = 1'b1; end
      INT_VEC: begin c.count = 2'd1; c.int_active = 1'b1; c.vec_rd = 1'b1;
                     c.flush = 1'b1; end
      RET_PC:  begin c.count = 2'd1; c.mem_op = MEM_POP; c.pc_from_mem = 1'b1;
                     c.flush = 1'b1; end
      RTI_FLG: begin c.count = 2'd2; c.mem_op = MEM_POP; c.flags_from_mem = 1'b1;
                     c.flush = 1'b1; end
      RTI_PC:  begin c.count = 2'd1; c.mem_op = MEM_POP; c.pc_from_mem = 1'b1;
                     c.flush = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_r;
  state_t state_next_s;
  logic   pending_r;
  logic   int_ack_s;
  logic   int_seq_s;
  ctrl_t  ctrl_r;
  ctrl_t  ctrl_next_s;

  assign int_seq_s   = (state_r == INT_PC) || (state_r == INT_FLG) || (state_r == INT_VEC);
  assign ctrl_next_s = decode_ctrl(state_next_s);

  // Next-state selection; returns take priority over a pending interrupt.
  always_comb begin
    state_next_s = state_r;
    int_ack_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ret_ex) begin
          state_next_s = RET_PC;
        end else if (rti_ex) begin
          state_next_s = RTI_FLG;
        end else if ((pending_r || int_req) && !load_stall) begin
          state_next_s = INT_PC;
          int_ack_s    = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      INT_PC:  state_next_s = INT_FLG;
      INT_FLG: state_next_s = INT_VEC;
      INT_VEC: state_next_s = IDLE;
      RET_PC:  state_next_s = IDLE;
      RTI_FLG: state_next_s = RTI_PC;
      RTI_PC:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, pending flag and control word registered together, so the outputs
  // always match the state they were decoded from.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      ctrl_r    <= '0;
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= ctrl_next_s;
      if (int_ack_s) begin
        pending_r <= 1'b0;
      end else if (int_req && !int_seq_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign count          = ctrl_r.count;
  assign int_active     = ctrl_r.int_active;
  assign mem_op         = ctrl_r.mem_op;
  assign mem_src        = ctrl_r.mem_src;
  assign vec_rd         = ctrl_r.vec_rd;
  assign pc_from_mem    = ctrl_r.pc_from_mem;
  assign flags_from_mem = ctrl_r.flags_from_mem;
  assign flush          = ctrl_r.flush;
  // int_ack is the one Mealy output: it marks the accepting IDLE cycle itself.
  assign int_ack        = int_ack_s && !rst;

endmodule

// File: tb/tb_int_ret_sequencer.sv
// Directed bench for int_ret_sequencer: reset, INT entry, RET, RTI, priority,
// load-stall deferral and reset in the middle of a sequence.
module tb_int_ret_sequencer;

  logic       clk = 1'b0;
  logic       rst, int_req, ret_ex, rti_ex, load_stall;
  logic [1:0] count, mem_op;
  logic       int_active, int_ack, mem_src, vec_rd, pc_from_mem, flags_from_mem, flush;

  int check_cnt = 0;
  int err_cnt   = 0;
  int ack_cnt   = 0;
  int ack_base;

  always #5 clk = ~clk;

  int_ret_sequencer dut (
    .clk(clk), .rst(rst), .int_req(int_req), .ret_ex(ret_ex), .rti_ex(rti_ex),
    .load_stall(load_stall), .count(count), .int_active(int_active),
    .int_ack(int_ack), .mem_op(mem_op), .mem_src(mem_src), .vec_rd(vec_rd),
    .pc_from_mem(pc_from_mem), .flags_from_mem(flags_from_mem), .flush(flush)
  );

  always @(negedge clk) if (int_ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected control word: {count, int_active, mem_op, mem_src, vec_rd, pc_mem, flg_mem, flush}
  task automatic check_ctrl(input string tag, input logic [1:0] c, input logic ia,
                            input logic [1:0] mo, input logic ms, input logic vr,
                            input logic pm, input logic fm, input logic fl);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".int_active"}, 32'(int_active), 32'(ia));
    check({tag, ".mem_op"}, 32'(mem_op), 32'(mo));
    check({tag, ".mem_src"}, 32'(mem_src), 32'(ms));
    check({tag, ".vec_rd"}, 32'(vec_rd), 32'(vr));
    check({tag, ".pc_from_mem"}, 32'(pc_from_mem), 32'(pm));
    check({tag, ".flags_from_mem"}, 32'(flags_from_mem), 32'(fm));
    check({tag, ".flush"}, 32'(flush), 32'(fl));
  endtask

  initial begin
    rst = 1'b1; int_req = 1'b0; ret_ex = 1'b0; rti_ex = 1'b0; load_stall = 1'b0;
    step(); step();
    check_ctrl("reset", 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.int_ack", 32'(int_ack), 32'd0);
    rst = 1'b0;
    step(); step();
    check_ctrl("post_reset_idle", 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Interrupt entry from IDLE; stray ret_ex/int_req mid-sequence are ignored
    ack_base = ack_cnt;
    int_req = 1'b1; #1;
    check("int.ack_cycle", 32'(int_ack), 32'd1);
    step(); int_req = 1'b0;
    check_ctrl("int.pc", 2'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ret_ex = 1'b1; int_req = 1'b1;
    step(); ret_ex = 1'b0; int_req = 1'b0;
    check_ctrl("int.flg", 2'd2, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_ctrl("int.vec", 2'd1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check_ctrl("int.idle", 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("int.absorbed", 32'(count), 32'd0);
    check("int.ack_once", 32'(ack_cnt - ack_base), 32'd1);

    // RTI: flags then PC popped
    rti_ex = 1'b1;
    step(); rti_ex = 1'b0;
    check_ctrl("rti.flg", 2'd2, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_ctrl("rti.pc", 2'd1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_ctrl("rti.idle", 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // int_req together with ret_ex: RET first, then interrupt entry
    ack_base = ack_cnt;
    int_req = 1'b1; ret_ex = 1'b1; #1;
    check("ret_int.no_ack", 32'(int_ack), 32'd0);
    step(); int_req = 1'b0; ret_ex = 1'b0;
    check_ctrl("ret_int.ret", 2'd1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ret_int.ret_ack", 32'(int_ack), 32'd0);
    step();
    check("ret_int.idle_count", 32'(count), 32'd0);
    check("ret_int.idle_ack", 32'(int_ack), 32'd1);
    step();
    check_ctrl("ret_int.pc", 2'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("ret_int.flg_count", 32'(count), 32'd2);
    step();
    check("ret_int.vec_count", 32'(count), 32'd1);
    step();
    check("ret_int.done", 32'(count), 32'd0);
    check("ret_int.ack_once", 32'(ack_cnt - ack_base), 32'd1);

    // load_stall defers entry
    load_stall = 1'b1; int_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.no_ack", 32'(int_ack), 32'd0);
      step(); int_req = 1'b0;
      check("stall.count", 32'(count), 32'd0);
    end
    load_stall = 1'b0; #1;
    check("stall.release_ack", 32'(int_ack), 32'd1);
    step();
    check_ctrl("stall.pc", 2'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); step(); step();
    check("stall.done", 32'(count), 32'd0);

    // Reset during INT_FLG, then fresh sequence
    int_req = 1'b1;
    step(); int_req = 1'b0;
    step();
    check("rst_mid.flg", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    check_ctrl("rst_mid.idle", 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); step();
    check("rst_mid.stay_idle", 32'(count), 32'd0);
    int_req = 1'b1;
    step(); int_req = 1'b0;
    check("fresh.pc", 32'(count), 32'd3);
    step();
    check("fresh.flg", 32'(count), 32'd2);
    step();
    check("fresh.vec", 32'(vec_rd), 32'd1);
    step();
    check("fresh.idle", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
